// File: rtl/scoreboard_pkg.sv
// Shared definitions for the scoreboard readout: FSM encoding, default frame tag
// and frame length as a function of counter width.
package scoreboard_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEND   = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_TAG = 8'hA5;

    // Tag byte, both counters byte by byte, then the checksum byte.
    function automatic int frame_len(input int width);
        return 2 + 2 * (width / 8);
    endfunction

endpackage

// File: rtl/frame_serializer.sv
// Sends TAG, a captured word MSB byte first, then a running XOR checksum
// over a valid/ready byte stream.
module frame_serializer
    import scoreboard_pkg::*;
#(
    parameter int         WORD_W = 64,
    parameter logic [7:0] TAG    = DEFAULT_TAG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              last_accept
);

    localparam int N     = frame_len(WORD_W / 2);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(N - 2);

    logic [WORD_W-1:0] shadow;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        csum;
    logic              accept;

    assign accept      = tx_valid && tx_ready;
    assign last_accept = accept && (idx == LAST_IDX);

    // NOTE: non-blocking for all state so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow   <= '0;
            idx      <= '0;
            csum     <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shadow   <= word;
            idx      <= '0;
            csum     <= '0;
            tx_data  <= TAG;
            tx_valid <= 1'b1;
        end else if (accept) begin
            csum <= csum ^ tx_data;
            if (idx == LAST_IDX) begin
                tx_valid <= 1'b0;
                idx      <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
                // The checksum byte folds in the byte being accepted right now.
                if (idx == CSUM_IDX) begin
                    tx_data <= csum ^ tx_data;
                end else begin
                    tx_data <= shadow[WORD_W-1 -: 8];
                    shadow  <= {shadow[WORD_W-9:0], 8'h00};
                end
            end
        end
    end

endmodule

// File: rtl/scoreboard_readout.sv
// Freezes the scoreboard, captures both counters after one settle cycle,
// streams them as a checksummed byte frame and then releases the freeze.
module scoreboard_readout
    import scoreboard_pkg::*;
#(
    parameter int         WIDTH = 32,
    parameter logic [7:0] TAG   = DEFAULT_TAG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    output logic             o_busy,
    output logic             o_freeze,
    input  logic [WIDTH-1:0] i_event_ctr,
    input  logic [WIDTH-1:0] i_data_ctr,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_done
);

    state_t state, state_nx;
    logic   freeze_nx, busy_nx, done_nx;
    logic   load, last_accept;

    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nx  = state;
        freeze_nx = o_freeze;
        busy_nx   = o_busy;
        done_nx   = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (i_req) begin
                    state_nx  = SETTLE;
                    freeze_nx = 1'b1;
                    busy_nx   = 1'b1;
                end
            end
            SETTLE: begin
                // Scoreboard has seen freeze for a full cycle, counters are final.
                load     = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                if (last_accept) begin
                    state_nx  = IDLE;
                    freeze_nx = 1'b0;
                    busy_nx   = 1'b0;
                    done_nx   = 1'b1;
                end
            end
            default: begin
                state_nx  = IDLE;
                freeze_nx = 1'b0;
                busy_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            o_freeze <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state    <= state_nx;
            o_freeze <= freeze_nx;
            o_busy   <= busy_nx;
            o_done   <= done_nx;
        end
    end

    frame_serializer #(
        .WORD_W(2 * WIDTH),
        .TAG   (TAG)
    ) u_serializer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .word       ({i_event_ctr, i_data_ctr}),
        .tx_data    (o_tx_data),
        .tx_valid   (o_tx_valid),
        .tx_ready   (i_tx_ready),
        .last_accept(last_accept)
    );

endmodule

// File: tb/tb_scoreboard_readout.sv
// Bench for scoreboard_readout with a small behavioural scoreboard attached;
// frames are collected off the stream and compared with a frame model.
module tb_scoreboard_readout;

    logic        clk;
    logic        reset;
    logic        req;
    logic        busy, freeze, tx_valid, done;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [31:0] sb_evt, sb_dat;

    // Scoreboard stimulus and preload
    logic        ev, ds, sb_ld;
    logic [31:0] ld_evt, ld_dat;
    logic        rand_ready, rand_strobe;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0]  rx_q[$];
    logic [31:0] snap_evt, snap_dat;
    logic        stalled = 1'b0;
    logic [7:0]  held_byte = 8'h00;

    scoreboard_readout #(.WIDTH(32), .TAG(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (req),
        .o_busy     (busy),
        .o_freeze   (freeze),
        .i_event_ctr(sb_evt),
        .i_data_ctr (sb_dat),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: counts strobes unless frozen at the edge.
    always @(posedge clk) begin
        if (sb_ld) begin
            sb_evt <= ld_evt;
            sb_dat <= ld_dat;
        end else if (!freeze) begin
            if (ev) sb_evt <= sb_evt + 32'd1;
            if (ds) sb_dat <= sb_dat + 32'd1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Byte collector and backpressure stability monitor.
    always @(negedge clk) begin
        if (stalled && !reset)
            check("hold_stable", {7'd0, tx_valid, tx_data}, {7'd0, 1'b1, held_byte});
        stalled   = tx_valid && !tx_ready;
        held_byte = tx_data;
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
        if (rand_strobe) begin
            ev = ($urandom_range(0, 1) == 1);
            ds = ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic preload(input logic [31:0] e, input logic [31:0] d);
        ld_evt = e;
        ld_dat = d;
        sb_ld  = 1'b1;
        tick();
        sb_ld  = 1'b0;
    endtask

    // Drive the request through one edge; the snapshot is the count after that edge.
    task automatic start_req(input logic hold);
        req = 1'b1;
        tick();
        snap_evt = sb_evt;
        snap_dat = sb_dat;
        if (!hold) req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, done, 1'b1);
    endtask

    task automatic wait_bytes(input int count);
        int n = 0;
        while (rx_q.size() < count && n < 400) begin
            tick();
            n++;
        end
        check("byte_wait", 64'(rx_q.size()), 64'(count));
    endtask

    // Frame model: tag, event counter bytes MSB first, data counter bytes, XOR of all.
    task automatic check_frame(input string name);
        logic [7:0] exp_q[$];
        logic [7:0] x;
        exp_q.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) exp_q.push_back(snap_evt[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(snap_dat[8*i +: 8]);
        x = 8'h00;
        foreach (exp_q[k]) x = x ^ exp_q[k];
        exp_q.push_back(x);
        check({name, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
        rx_q.delete();
    endtask

    typedef struct {
        logic [31:0] evt;
        logic [31:0] dat;
        logic [7:0]  csum;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [7:0] t1[10];
        int         n;
        int         d0;
        logic [7:0] b3;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 8'hA5};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hA5};
        vecs[2] = '{32'h1234_5678, 32'h0000_0001, 8'hAC};
        vecs[3] = '{32'h0000_00FF, 32'h8000_0000, 8'hDA};
        vecs[4] = '{32'hDEAD_BEEF, 32'h0000_0000, 8'h87};
        t1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hAC};

        reset = 1'b1; req = 1'b0; tx_ready = 1'b1; ev = 1'b0; ds = 1'b0;
        sb_ld = 1'b0; ld_evt = '0; ld_dat = '0; rand_ready = 1'b0; rand_strobe = 1'b0;
        sb_evt = '0; sb_dat = '0;
        #2;
        check("reset_outputs", {busy, freeze, tx_valid, done, tx_data}, 12'h000);
        tick();
        tick();
        reset = 1'b0;

        // 3 events over 10 unfrozen cycles, then a request with ready held high.
        preload(32'd0, 32'd0);
        ds = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ev = (i % 3 == 0);
            tick();
        end
        ev = 1'b0;
        start_req(1'b0);
        check("t1_freeze_rise", {freeze, busy}, 2'b11);
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
            if (!done) check("t1_freeze_held", freeze, 1'b1);
        end
        check("t1_latency", 64'(n), 64'd11);
        check("t1_release", {freeze, busy, tx_valid}, 3'b000);
        check("t1_frozen_cnt", {sb_evt, sb_dat}, {snap_evt, snap_dat});
        for (int i = 0; i < 10 && i < rx_q.size(); i++)
            check($sformatf("t1_const%0d", i), rx_q[i], t1[i]);
        check_frame("t1");
        tick();
        check("t1_done_pulse", done, 1'b0);
        check("t1_resume", sb_dat, snap_dat + 32'd1);
        ds = 1'b0;

        // Table vectors with boundary counter values and random backpressure.
        rand_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            preload(vecs[v].evt, vecs[v].dat);
            start_req(1'b0);
            wait_done($sformatf("vec%0d", v));
            if (rx_q.size() == 10) check($sformatf("vec%0d_csum", v), rx_q[9], vecs[v].csum);
            check($sformatf("vec%0d_snap", v), {snap_evt, snap_dat}, {vecs[v].evt, vecs[v].dat});
            check_frame($sformatf("vec%0d", v));
        end
        rand_ready = 1'b0;
        tx_ready = 1'b1;
        tick();

        // Ready low for 5 cycles while byte 3 is presented; counters must not move.
        preload(32'h1122_3344, 32'h5566_7788);
        start_req(1'b0);
        ev = 1'b1; ds = 1'b1;
        wait_bytes(3);
        tx_ready = 1'b0;
        b3 = tx_data;
        check("t2_byte3", {tx_valid, b3}, {1'b1, 8'h33});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall", {tx_valid, tx_data}, {1'b1, b3});
            check("t2_cnt_frozen", {sb_evt, sb_dat}, {snap_evt, snap_dat});
        end
        tx_ready = 1'b1;
        wait_done("t2");
        check_frame("t2");

        // Event held high during readout: snapshot at freeze, counting resumes after.
        ev = 1'b1; ds = 1'b0;
        tick(); tick();
        start_req(1'b0);
        wait_done("t3");
        check("t3_frozen_evt", sb_evt, snap_evt);
        check_frame("t3");
        tick(); tick();
        check("t3_resume", sb_evt, snap_evt + 32'd2);
        ev = 1'b0;

        // Request while busy is ignored.
        d0 = done_cnt;
        start_req(1'b0);
        wait_bytes(4);
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_done("t4");
        check_frame("t4");
        for (int i = 0; i < 20; i++) tick();
        check("t4_one_frame", 64'(done_cnt - d0), 64'd1);
        check("t4_no_extra", {32'(rx_q.size()), 31'd0, busy}, 64'd0);

        // Asynchronous reset during byte 6, then a fresh frame.
        start_req(1'b0);
        wait_bytes(6);
        #2 reset = 1'b1;
        #1 check("t5_reset_now", {freeze, tx_valid, busy}, 3'b000);
        tick();
        reset = 1'b0;
        rx_q.delete();
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_resume", {tx_valid, busy, 32'(rx_q.size())}, 34'd0);
        preload(32'hCAFE_0001, 32'h0BAD_F00D);
        start_req(1'b0);
        wait_done("t5");
        check_frame("t5");

        // Request held high: back-to-back frames, second starts on the done edge.
        rand_ready = 1'b1; rand_strobe = 1'b1;
        start_req(1'b1);
        wait_done("t6a");
        check_frame("t6a");
        tick();
        snap_evt = sb_evt;
        snap_dat = sb_dat;
        check("t6_restart", {busy, done}, 2'b10);
        wait_done("t6b");
        req = 1'b0;
        check_frame("t6b");

        // Randomized counters, strobes and backpressure.
        for (int r = 0; r < 10; r++) begin
            preload($urandom, $urandom);
            start_req(1'b0);
            wait_done("rnd");
            check("rnd_frozen", {sb_evt, sb_dat}, {snap_evt, snap_dat});
            check_frame($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scoreboard_readout.md
Name: scoreboard_readout

Overview:
Initiator-side reader for the scoreboard counter pair.
- On request, it freezes the scoreboard and captures a consistent snapshot of the event and data counters.
- It then transmits the snapshot as a byte frame over a valid/ready stream, toward the host link or UART, and releases the freeze.
- It sits between the scoreboard and the host-facing byte transport.

Parameters:
- WIDTH, 32, width of each scoreboard counter; must be a multiple of 8 and at least 8.
- TAG, 8'hA5, header byte that opens every frame.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- i_req  input  1  readout request; level, sampled only in IDLE.
- o_busy  output  1  high from request accept until frame completion.
- o_freeze  output  1  drives the scoreboard i_freeze.
- i_event_ctr  input  WIDTH  scoreboard event counter.
- i_data_ctr  input  WIDTH  scoreboard data counter.
- o_tx_data  output  8  frame byte.
- o_tx_valid  output  1  o_tx_data valid.
- i_tx_ready  input  1  downstream accepts a byte when valid and ready are both high at a clk edge.
- o_done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset:
  - All outputs are 0: o_busy, o_freeze, o_tx_valid, o_done, o_tx_data.
  - State is IDLE; shadow registers, byte index and checksum are cleared.
  - Reset is asynchronous at any point, including mid-frame. The frame is abandoned, freeze is released immediately and nothing resumes.
- States: IDLE, SETTLE, SEND.
- All outputs are registered.
- IDLE:
  - If i_req=1 at edge E0, then o_freeze=1, o_busy=1 and the state goes to SETTLE.
  - If i_req=0, nothing changes.
- SETTLE (exactly one cycle):
  - Counters are final after E0, because the scoreboard samples freeze=1 from E1 onward.
  - At E1: shadow_evt<=i_event_ctr, shadow_dat<=i_data_ctr, o_tx_data<=TAG, o_tx_valid<=1, checksum<=0, byte index<=0, state goes to SEND.
- Frame order, N = 2 + 2*WIDTH/8 bytes (10 for WIDTH=32):
  - TAG.
  - shadow_evt bytes, MSB first.
  - shadow_dat bytes, MSB first.
  - Checksum byte: XOR of all preceding frame bytes, TAG included.
- SEND:
  - o_tx_data and o_tx_valid hold stable while i_tx_ready=0. Backpressure has no limit, and o_freeze stays 1 throughout.
  - On each accepted byte: checksum^=o_tx_data, the index increments, and the next byte is presented in the following cycle with valid kept high. There are no bubbles.
- Completion, at the edge accepting the checksum byte:
  - o_tx_valid<=0, o_freeze<=0, o_busy<=0, o_done<=1, state goes to IDLE.
  - o_done clears the following cycle.
- i_req while busy is ignored; there is no queuing.
- If i_req is high in the o_done cycle, the next frame starts at that edge and o_done still clears.
- Latency:
  - From the i_req-sampling edge to the first valid byte: 2 edges.
  - With ready held high, the frame completes N edges after the first valid byte.
- Input changes during SETTLE or SEND are ignored; only the shadow copies are sent.
- Counter wrap is not special-cased; the raw captured values are sent.

Decomposition:
- Shared package (scoreboard_pkg) holds:
  - the state encoding constants (IDLE/SETTLE/SEND);
  - the default TAG value;
  - the frame length function of WIDTH.
- One natural sub-module, frame_serializer:
  - takes a 2*WIDTH-bit word plus TAG;
  - emits bytes over valid/ready with the running XOR checksum.
- The top level keeps the freeze/capture FSM.

Test Plan (WIDTH=32, TAG=A5, real scoreboard instance connected):
- 3 events in 10 unfrozen cycles, then i_req pulse, ready held high -> bytes A5 00 00 00 03 00 00 00 0A AC; freeze high from req+1 to after the AC accept; o_done is a single pulse.
- i_tx_ready low for 5 cycles while byte index 3 is presented -> o_tx_data/o_tx_valid stable; scoreboard counters unchanged; the frame then completes correctly.
- i_event held high continuously during readout -> captured event count equals the value at freeze assertion; counters resume incrementing after release.
- i_req asserted again at byte 4 -> ignored; exactly one frame emitted.
- reset asserted during byte 6 -> o_freeze, o_tx_valid and o_busy go 0 immediately; a later i_req produces a complete fresh frame starting with A5.
- i_req held high continuously -> back-to-back frames; the second starts at the o_done edge; each frame's checksum is correct.
